// File: rtl/branch_pkg.sv
// Shared branch-resolution types: funct3 encodings, BHT counter type and its
// saturating update rule.
package branch_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT = 2'b00;
  localparam bht_ctr_t CTR_WNT = 2'b01;
  localparam bht_ctr_t CTR_WT  = 2'b10;
  localparam bht_ctr_t CTR_ST  = 2'b11;

  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : bht_ctr_t'(ctr + 2'd1);
    end
    return (ctr == CTR_SNT) ? CTR_SNT : bht_ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch request and registered resolution bus of branch_resolve_unit.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            flush;
  logic            res_valid;
  logic            res_taken;
  logic            res_mispredict;
  logic [XLEN-1:0] res_pc;

  modport master (
    output ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken, flush,
    input  res_valid, res_taken, res_mispredict, res_pc
  );

  modport slave (
    input  ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken, flush,
    output res_valid, res_taken, res_mispredict, res_pc
  );
endinterface

// File: rtl/branch_cmp.sv
// Combinational XLEN-wide branch comparator; flags funct3 codes that are not
// conditional branches.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_u = (rs1 < rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: compare, one-cycle registered outcome, mispredict flag
// and 2-bit BHT. Optional counters enabled by macro BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter bht_ctr_t    BHT_INIT    = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XLEN-1:0]        pred_pc,
  output logic                   pred_taken,
  branch_resolve_unit_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]            stat_branches,
  output logic [31:0]            stat_mispredicts
`endif
);

  localparam int unsigned IDXW = $clog2(BHT_ENTRIES);

  bht_ctr_t        bht [BHT_ENTRIES];
  logic [IDXW-1:0] pred_idx;
  logic [IDXW-1:0] ex_idx;
  logic            cmp_taken;
  logic            cmp_illegal;
  logic            accept;
  logic            mispredict;
  logic            unused_pred_bits;

  assign pred_idx = pred_pc[IDXW+1:2];
  assign ex_idx   = bus.ex_pc[IDXW+1:2];
  assign unused_pred_bits = ^{pred_pc[XLEN-1:IDXW+2], pred_pc[1:0]};

  // Read straight from the array so a same-cycle update is not forwarded.
  assign pred_taken = bht[pred_idx][1];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3  (bus.ex_funct3),
    .rs1     (bus.ex_rs1),
    .rs2     (bus.ex_rs2),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign accept     = bus.ex_valid && !bus.flush;
  assign mispredict = cmp_taken != bus.ex_pred_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid      <= 1'b0;
      bus.res_taken      <= 1'b0;
      bus.res_mispredict <= 1'b0;
      bus.res_pc         <= '0;
    end else begin
      bus.res_valid <= accept;
      if (accept) begin
        bus.res_taken      <= cmp_taken;
        bus.res_mispredict <= mispredict;
        bus.res_pc         <= bus.ex_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= BHT_INIT;
      end
    end else if (accept && !cmp_illegal) begin
      bht[ex_idx] <= ctr_next(bht[ex_idx], cmp_taken);
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (16),
    .BHT_INIT    (2'b01)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .bus              (bus.slave)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: counters as integers 0..3, plain arithmetic compares.
  int          m_ctr [16];
  bit          m_valid, m_taken, m_mis;
  logic [31:0] m_pc;
  int unsigned m_sb, m_sm;

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, output bit ill);
    longint sa = longint'(int'(a));
    longint sb = longint'(int'(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    ill = 1'b0;
    case (f3)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd7: return ua >= ub;
      default: begin ill = 1'b1; return 1'b0; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  task automatic model_edge(input bit r, input bit v, input bit fl, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input bit pt);
    bit t, ill;
    if (r) begin
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_valid = 0; m_taken = 0; m_mis = 0; m_pc = '0; m_sb = 0; m_sm = 0;
    end else begin
      m_valid = 0;
      if (v && !fl) begin
        t = ref_taken(f3, a, b, ill);
        m_valid = 1; m_taken = t; m_mis = (t != pt); m_pc = pc;
        m_sb++;
        if (m_mis) m_sm++;
        if (!ill) begin
          if (t) m_ctr[idx_of(pc)] = (m_ctr[idx_of(pc)] == 3) ? 3 : m_ctr[idx_of(pc)] + 1;
          else   m_ctr[idx_of(pc)] = (m_ctr[idx_of(pc)] == 0) ? 0 : m_ctr[idx_of(pc)] - 1;
        end
      end
    end
  endtask

  // One clock: drive, check the lookup before the edge, check results after it.
  task automatic cycle(input bit r, input bit v, input bit fl, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input bit pt, input logic [31:0] ppc, output bit pre_pred);
    rst = r; bus.ex_valid = v; bus.flush = fl; bus.ex_funct3 = f3;
    bus.ex_rs1 = a; bus.ex_rs2 = b; bus.ex_pc = pc; bus.ex_pred_taken = pt;
    pred_pc = ppc;
    #1;
    pre_pred = pred_taken;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_ctr[idx_of(ppc)] >= 2});
    @(posedge clk);
    model_edge(r, v, fl, f3, a, b, pc, pt);
    #1;
    chk("res_valid", {31'd0, bus.res_valid}, {31'd0, m_valid});
    chk("res_taken", {31'd0, bus.res_taken}, {31'd0, m_taken});
    chk("res_mispredict", {31'd0, bus.res_mispredict}, {31'd0, m_mis});
    chk("res_pc", bus.res_pc, m_pc);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, m_sb);
    chk("stat_mispredicts", stat_mispredicts, m_sm);
`endif
  endtask

  typedef struct {
    bit          v, fl;
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          pt;
    bit          e_valid, e_taken, e_mis;
  } vec_t;

  initial begin
    vec_t tbl [12];
    bit   p;

    tbl[0]  = '{1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 0, 1, 1, 1};
    tbl[1]  = '{1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 3'b000, 32'h5, 32'h5, 1, 1, 1, 0};
    tbl[3]  = '{1, 0, 3'b001, 32'h5, 32'h5, 1, 1, 0, 1};
    tbl[4]  = '{1, 0, 3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1, 0, 0};
    tbl[5]  = '{1, 0, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1, 1, 1};
    tbl[6]  = '{1, 0, 3'b010, 32'h3, 32'h3, 1, 1, 0, 1};
    tbl[7]  = '{1, 1, 3'b000, 32'h3, 32'h3, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 3'b000, 32'h3, 32'h3, 0, 0, 0, 1};
    tbl[9]  = '{1, 0, 3'b101, 32'h7, 32'h7, 0, 1, 1, 1};
    tbl[10] = '{1, 0, 3'b100, 32'h7, 32'h7, 0, 1, 0, 0};
    tbl[11] = '{1, 0, 3'b001, 32'h3, 32'h4, 1, 1, 1, 0};

    // Reset state
    cycle(1, 0, 0, 3'd0, 0, 0, 0, 0, 32'h40, p);
    cycle(1, 1, 0, 3'd0, 1, 1, 32'h40, 0, 32'h40, p);
    cycle(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h40, p);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    chk("rst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_pc", bus.res_pc, 32'd0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      cycle(0, tbl[i].v, tbl[i].fl, tbl[i].f3, tbl[i].a, tbl[i].b,
            32'h200 + 32'(i) * 4, tbl[i].pt, 32'h40, p);
      chk("tbl_valid", {31'd0, bus.res_valid}, {31'd0, tbl[i].e_valid});
      chk("tbl_taken", {31'd0, bus.res_taken}, {31'd0, tbl[i].e_taken});
      chk("tbl_mis", {31'd0, bus.res_mispredict}, {31'd0, tbl[i].e_mis});
    end

    // Saturation at 0x100 and aliasing at 0x140
    cycle(1, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100, p);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 3'b000, 9, 9, 32'h100, 0, 32'h100, p);
      chk("sat_pre", {31'd0, p}, (i == 0) ? 32'd0 : 32'd1);
    end
    chk("sat_after", {31'd0, pred_taken}, 32'd1);
    pred_pc = 32'h140; #1;
    chk("alias_140", {31'd0, pred_taken}, 32'd1);
    cycle(0, 1, 0, 3'b001, 9, 9, 32'h100, 1, 32'h100, p);
    chk("sat_one_down", {31'd0, pred_taken}, 32'd1);
    cycle(0, 1, 0, 3'b001, 9, 9, 32'h100, 1, 32'h100, p);
    chk("sat_two_down", {31'd0, pred_taken}, 32'd0);

    // Read-before-write collision on index 5
    cycle(1, 0, 0, 3'd0, 0, 0, 0, 0, 32'h14, p);
    cycle(0, 1, 0, 3'b000, 2, 2, 32'h14, 0, 32'h14, p);
    chk("collide_pre", {31'd0, p}, 32'd0);
    chk("collide_post", {31'd0, pred_taken}, 32'd1);

    // Flush and illegal funct3 must leave the counter (10) alone
    cycle(0, 1, 1, 3'b001, 2, 2, 32'h14, 0, 32'h14, p);
    chk("flush_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("flush_ctr", {31'd0, pred_taken}, 32'd1);
    cycle(0, 1, 0, 3'b010, 2, 2, 32'h14, 1, 32'h14, p);
    chk("ill_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("ill_mis", {31'd0, bus.res_mispredict}, 32'd1);
    chk("ill_ctr", {31'd0, pred_taken}, 32'd1);
    cycle(0, 1, 0, 3'b011, 2, 2, 32'h14, 0, 32'h14, p);
    chk("ill2_ctr", {31'd0, pred_taken}, 32'd1);

`ifdef BRANCH_STATS_EN
    cycle(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, p);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 3'b000, 1, 1, 32'h20, (i % 2) == 0, 0, p);
    cycle(1, 1, 0, 3'b000, 1, 1, 32'h20, 0, 0, p);
    chk("stat_clr_b", stat_branches, 32'd0);
    chk("stat_clr_m", stat_mispredicts, 32'd0);
    cycle(0, 1, 0, 3'b000, 1, 1, 32'h20, 0, 0, p);
    cycle(0, 1, 0, 3'b000, 1, 2, 32'h20, 0, 0, p);
    cycle(0, 1, 0, 3'b001, 1, 2, 32'h20, 0, 0, p);
    cycle(0, 1, 0, 3'b100, 1, 2, 32'h20, 1, 0, p);
    chk("stat_b4", stat_branches, 32'd4);
    chk("stat_m2", stat_mispredicts, 32'd2);
`endif

    // Randomized traffic with occasional reset and flush
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ops [4];
      logic [31:0] pc;
      ops[0] = 32'h0; ops[1] = 32'hFFFF_FFFF; ops[2] = 32'h8000_0000; ops[3] = $urandom;
      pc = 32'($urandom_range(0, 31)) * 4;
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            3'($urandom_range(0, 7)), ops[$urandom_range(0, 3)], ops[$urandom_range(0, 3)],
            pc, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? pc : 32'($urandom_range(0, 31)) * 4, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Performs its own XLEN-wide signed/unsigned compare of rs1/rs2 instead of consuming ALU flags.
- Registers the branch outcome and detects mispredictions.
- Maintains a 2-bit saturating-counter branch history table (BHT) that fetch reads for the next prediction.
- Sits between the EX stage and the PC-select/flush logic.

Parameters:
- XLEN, 32: operand and PC width.
- BHT_ENTRIES, 16: number of 2-bit counters; power of two, 2..1024.
- BHT_INIT, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pred_pc  in  XLEN  fetch-stage PC for BHT lookup.
- pred_taken  out  1  combinational prediction: MSB of BHT[pred_pc index].
- ex_valid  in  1  EX stage holds a conditional branch this cycle.
- ex_funct3  in  3  branch funct3.
- ex_rs1  in  XLEN  source operand 1.
- ex_rs2  in  XLEN  source operand 2.
- ex_pc  in  XLEN  PC of the branch in EX.
- ex_pred_taken  in  1  prediction made at fetch, carried down the pipeline.
- flush  in  1  kill the EX-stage branch (older redirect).
- res_valid  out  1  registered: resolution available.
- res_taken  out  1  registered: actual outcome.
- res_mispredict  out  1  registered: res_taken != ex_pred_taken.
- res_pc  out  XLEN  registered: PC of the resolved branch.
- stat_branches  out  32  only with BRANCH_STATS_EN.
- stat_mispredicts  out  32  only with BRANCH_STATS_EN.

Behaviour:
- Index: idx = pc[IDXW+1:2], where IDXW = clog2(BHT_ENTRIES). Same mapping for pred_pc and ex_pc.
- Compare by funct3 (full XLEN width):
  - 000 BEQ: rs1 == rs2.
  - 001 BNE: rs1 != rs2.
  - 100 BLT: signed rs1 < rs2.
  - 101 BGE: signed rs1 >= rs2.
  - 110 BLTU: unsigned rs1 < rs2.
  - 111 BGEU: unsigned rs1 >= rs2.
- Illegal funct3 (010, 011): taken = 0, mispredict = ex_pred_taken, BHT not updated, res_valid still asserted.
- Latency: one cycle. If ex_valid && !flush at edge N, res_* reflect that branch during cycle N+1.
- res_valid is high for exactly one cycle per accepted branch. Back-to-back branches are accepted every cycle.
- When no branch is accepted: res_valid = 0; res_taken, res_mispredict and res_pc hold their last values.
- BHT update happens at the same edge that captures res_* (legal funct3 only):
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- Read/write collision: if pred_pc and ex_pc map to the same index in one cycle, pred_taken reflects the pre-update value (read-before-write).
- flush has priority over ex_valid: no capture, no BHT update, res_valid = 0 next cycle.
- Reset (sync, on any edge with rst high, including mid-stream):
  - res_valid, res_taken, res_mispredict = 0; res_pc = 0.
  - All counters = BHT_INIT; stats = 0.
  - A branch presented while rst is high is dropped.
- pred_taken is purely combinational from table state; no handshake on the lookup port.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - stat_branches increments on every accepted branch.
  - stat_mispredicts increments when the captured mispredict is 1.
  - Both are 32-bit, wrap at 2^32-1 to 0, and are cleared by rst.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package branch_pkg:
  - funct3 constants (F3_BEQ .. F3_BGEU).
  - 2-bit counter typedef bht_ctr_t.
  - Constants CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11.
- One natural sub-module: branch_cmp, a combinational XLEN-parametrised comparator (funct3, rs1, rs2 -> taken, illegal).
- The BHT array and register stage stay in the top module.

Test Plan:
- Reset, then pred_pc = 0x40 -> pred_taken = 0. Next cycle res_valid = 0 and all res_* = 0.
- BLT with rs1 = 0xFFFFFFFF, rs2 = 1, ex_pred_taken = 0 -> next cycle res_taken = 1, res_mispredict = 1. BLTU with the same operands -> res_taken = 0, res_mispredict = 0.
- Four consecutive taken BEQ at ex_pc = 0x100 -> counter goes 01→10→11→11 (saturates). pred_pc = 0x100 reads 1 from the second update onward. pred_pc = 0x140 (aliases with BHT_ENTRIES = 16) also reads 1.
- Same-cycle lookup/update on index 5 with counter 01 and a taken branch -> pred_taken = 0 that cycle, 1 the next.
- ex_valid = 1 with flush = 1 -> res_valid = 0, counter unchanged. funct3 = 010 with ex_pred_taken = 1 -> res_valid = 1, res_taken = 0, res_mispredict = 1, no BHT change.
- With BRANCH_STATS_EN: 10 branches, 3 mispredicted, rst asserted mid-stream after 6 -> counters clear. After the 4 remaining branches, stats show 4 and the correct mispredict count for those 4.
